// File: rtl/parity_pkg.sv
// Shared types and constants for the streaming parity checker.
//   state_e  : frame-tracking FSM states
//   PAR_*    : parity mode encoding, matching the odd_mode input
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : add one, holds at all-ones
//   clr        : force to zero; wins over inc
//   cnt        : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming row/column parity checker. Each accepted beat carries a data word
// and its row-parity bit; the last beat is the column-parity check word. One
// frame is in flight at a time; its result is offered on a valid/ready port.
//   clk, rst_n        : clock, synchronous active-low reset
//   odd_mode          : 0 even / 1 odd parity, latched on first beat of frame
//   in_valid/in_ready : input beat handshake
//   in_data, in_par   : data word and its row-parity bit
//   in_last           : beat is the column check word
//   res_valid/ready   : frame result handshake
//   res_word_err      : some beat failed row parity
//   res_frame_err     : column parity failed
//   res_word_cnt      : beats in frame (saturating)
//   err_cnt, clr_err  : saturating count of bad frames, synchronous clear
//
// state  | meaning
// IDLE   | waiting for the first beat of a frame
// ACCUM  | mid-frame, accumulating row errors and column parity
// REPORT | result presented, input stalled until res_ready
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_word_err,
  output logic              res_frame_err,
  output logic [CNT_W-1:0]  res_word_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_err
);

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [DATA_W-1:0] col_acc_q, col_acc_d;
  logic              word_err_acc_q, word_err_acc_d;
  logic              res_word_err_q, res_word_err_d;
  logic              res_frame_err_q, res_frame_err_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic              mode_eff;
  logic              row_bad;
  logic              col_bad;
  logic              err_inc;
  logic              leave_report;
  logic [CNT_W-1:0]  word_cnt;

  assign accept       = in_valid & ready_q;
  // The first beat is checked against the mode it brings, not the stale latch.
  assign mode_eff     = (state_q == IDLE) ? odd_mode : mode_q;
  assign row_bad      = ((^in_data) ^ in_par) != mode_eff;
  // col_acc_q is zero in IDLE, so a single-beat frame compares in_data directly.
  assign col_bad      = (col_acc_q ^ in_data) != {DATA_W{mode_eff}};
  assign leave_report = (state_q == REPORT) & res_ready;
  assign err_inc      = accept & in_last & (word_err_acc_q | row_bad | col_bad);

  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    col_acc_d       = col_acc_q;
    word_err_acc_d  = word_err_acc_q;
    res_word_err_d  = res_word_err_q;
    res_frame_err_d = res_frame_err_q;

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (state_q == IDLE) begin
            mode_d = odd_mode;
          end
          if (in_last) begin
            state_d         = REPORT;
            res_word_err_d  = word_err_acc_q | row_bad;
            res_frame_err_d = col_bad;
            word_err_acc_d  = 1'b0;
            col_acc_d       = '0;
          end else begin
            state_d        = ACCUM;
            word_err_acc_d = word_err_acc_q | row_bad;
            col_acc_d      = col_acc_q ^ in_data;
          end
        end
      end
      REPORT: begin
        if (res_ready) begin
          state_d         = IDLE;
          res_word_err_d  = 1'b0;
          res_frame_err_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered ready keeps in_ready low through the reset cycle.
    ready_d = (state_d != REPORT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      mode_q          <= PAR_EVEN;
      col_acc_q       <= '0;
      word_err_acc_q  <= 1'b0;
      res_word_err_q  <= 1'b0;
      res_frame_err_q <= 1'b0;
      ready_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      col_acc_q       <= col_acc_d;
      word_err_acc_q  <= word_err_acc_d;
      res_word_err_q  <= res_word_err_d;
      res_frame_err_q <= res_frame_err_d;
      ready_q         <= ready_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept),
    .clr   (leave_report),
    .cnt   (word_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .clr   (clr_err),
    .cnt   (err_cnt)
  );

  assign in_ready      = ready_q;
  assign res_valid     = (state_q == REPORT);
  assign res_word_err  = res_word_err_q;
  assign res_frame_err = res_frame_err_q;
  assign res_word_cnt  = res_valid ? word_cnt : '0;

endmodule
